fft_input_buffer: RTL and testbench
===================================

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits.
REQ-002 Parameter N, default 8, FFT points per frame; only the value 8 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  buffer can accept a sample.
REQ-007 s_data  input  DATA_W  time-domain sample, natural order.
REQ-008 s_last  input  1  marks the final sample of a frame.
REQ-009 m_valid  output  1  complete bit-reversed frame available to the FFT datapath.
REQ-010 m_ready  input  1  FFT datapath accepts the frame.
REQ-011 m_data  output  N*DATA_W  packed frame; lane k occupies bits [k*DATA_W +: DATA_W] and drives datapath input k+1.
REQ-012 frame_err  output  1  one-cycle pulse on a short frame.

Function
REQ-013 Sample transfer occurs on a cycle with s_valid=1 and s_ready=1; frame transfer occurs on a cycle with m_valid=1 and m_ready=1.
REQ-014 Storage: two banks (ping-pong) of N words, each with a full flag; wr_bank, rd_bank 1-bit pointers; wr_idx 3-bit counter.
REQ-015 Accepted sample with index i is written to lane bitrev3(i) of bank wr_bank (0->0, 1->4, 2->2, 3->6, 4->1, 5->5, 6->3, 7->7).
REQ-016 s_ready = NOT full[wr_bank], derived only from registers with no combinational path from s_valid or m_ready.
REQ-017 On acceptance at wr_idx=7: full[wr_bank] set, wr_bank toggles, wr_idx wraps to 0; s_last is irrelevant at index 7.
REQ-018 On acceptance with s_last=1 at wr_idx<7: the partial frame is discarded, wr_idx returns to 0, wr_bank and full flags are unchanged, frame_err pulses high the next cycle.
REQ-019 m_valid = full[rd_bank]; m_data = bank rd_bank contents, held stable while m_valid=1 and m_ready=0.
REQ-020 On frame transfer: full[rd_bank] cleared, rd_bank toggles.
REQ-021 Latency: m_valid rises the cycle after the 8th sample is accepted when the other bank is empty.
REQ-022 Simultaneous frame completion on one bank and frame transfer from the other bank in the same cycle: both take effect; no sample is lost and no stall occurs.
REQ-023 With m_ready held 1, throughput is one sample per cycle sustained; s_ready never drops.
REQ-024 When both banks are full, s_ready=0 until a frame transfer; s_ready rises the cycle after that transfer.
REQ-025 Frames leave in the order they were completed.

Reset
REQ-026 rst_n low asynchronously clears full flags, wr_bank, rd_bank, wr_idx and frame_err, which gives m_valid=0 and s_ready=1.
REQ-027 Bank data storage is not reset; m_data content is don't-care while m_valid=0.
REQ-028 Reset asserted mid-frame discards the partial and any full frames; after release, the first accepted sample is index 0.

Structure
REQ-029 Shared package fft_pkg holds DATA_W, N, LOG2N=3 and the bitrev3 function, for reuse by the datapath and the output reorder stage.
REQ-030 One sub-module, fft_buf_bank (N x DATA_W register bank with lane write-enable and packed read), is instantiated twice.

Verification
REQ-031 Stream samples 0..7 with m_ready=1 -> m_valid high 1 cycle after the 8th sample; lanes 0..7 = 0,4,2,6,1,5,3,7.
REQ-032 Stream 24 samples back-to-back with m_ready=1 -> s_ready constant 1; three frames out in order, bases 0, 8, 16.
REQ-033 Hold m_ready=0, stream 17 samples -> s_ready=0 after sample 16; m_data stable; assert m_ready for 1 cycle -> s_ready=1 next cycle; sample 17 accepted.
REQ-034 s_last on 3rd sample (values 9,9,9) -> frame_err one pulse, no m_valid; following samples 0..7 produce a correct frame.
REQ-035 Assert rst_n=0 asynchronously after 5 samples -> m_valid=0 and s_ready=1 immediately; a fresh 8-sample frame after release reorders correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the radix-2 FFT front end.
//   Used by the input buffer, the butterfly datapath and the output
//   reorder stage, so that all of them agree on the frame geometry and
//   the bit-reversal permutation.
//
//   Contents:
//     DATA_W    - default sample width in bits
//     N         - FFT points per frame (only 8 is supported)
//     LOG2N     - index width for one frame
//     idx_t     - sample / lane index type
//     ctrl_t    - control state of the ping-pong input buffer
//     bitrev3() - 3-bit bit-reversal used to scatter samples into lanes
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int DATA_W = 8;
    localparam int N      = 8;
    localparam int LOG2N  = 3;

    typedef logic [LOG2N-1:0] idx_t;

    // Everything the input buffer keeps besides the sample storage itself.
    typedef struct packed {
        logic [1:0] full;      // one flag per bank: bank holds a complete frame
        logic       wr_bank;   // bank currently being filled
        logic       rd_bank;   // bank presented to the datapath
        idx_t       wr_idx;    // natural-order index of the next sample
        logic       frame_err; // registered short-frame pulse
    } ctrl_t;

    // Reverse the bit order of a 3-bit index: 1->4, 3->6, 6->3, ...
    function automatic idx_t bitrev3(input idx_t i);
        return {i[0], i[1], i[2]};
    endfunction

endpackage

// File: rtl/fft_input_buffer_if.sv
// ---------------------------------------------------------------------------
// fft_input_buffer_if
//   Handshake bundle around the FFT input buffer.
//
//   Sample side (upstream -> buffer):
//     s_valid, s_data[DATA_W], s_last  driven by upstream
//     s_ready                          driven by the buffer
//   Frame side (buffer -> FFT datapath):
//     m_valid, m_data[N*DATA_W]        driven by the buffer
//     m_ready                          driven by the datapath
//
//   Modports:
//     slave  - the buffer's view
//     master - the surrounding environment's view (source and sink)
// ---------------------------------------------------------------------------
interface fft_input_buffer_if #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int N      = fft_pkg::N
);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_data;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [N*DATA_W-1:0]   m_data;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/fft_buf_bank.sv
// ---------------------------------------------------------------------------
// fft_buf_bank
//   One frame of sample storage: N words of DATA_W bits, written one lane
//   at a time and read all lanes at once as a packed vector.
//
//   Ports:
//     clk    in   clock
//     we     in   write enable for this bank
//     lane   in   lane to write (already bit-reversed by the caller)
//     wdata  in   sample to store
//     rdata  out  packed frame, lane k at [k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module fft_buf_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int N      = fft_pkg::N
) (
    input  logic                clk,
    input  logic                we,
    input  idx_t                lane,
    input  logic [DATA_W-1:0]   wdata,
    output logic [N*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [N];

    // NOTE: the storage has no reset on purpose; contents only matter once a
    // full flag says the bank is complete, so a reset network here buys nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[lane] <= wdata;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            rdata[k*DATA_W +: DATA_W] = mem[k];
        end
    end

endmodule

// File: rtl/fft_input_buffer.sv
// ---------------------------------------------------------------------------
// fft_input_buffer
//   Ping-pong input buffer for an 8-point FFT. Samples arrive one per
//   transfer in natural order and are scattered into bit-reversed lanes,
//   so a completed bank can be handed to the datapath as one packed frame
//   while the other bank is being filled.
//
//   Ports:
//     clk        in    single clock, rising edge
//     rst_n      in    asynchronous active-low reset
//     bus        slave handshake bundle (s_valid/s_ready/s_data/s_last,
//                      m_valid/m_ready/m_data)
//     frame_err  out   one-cycle pulse after a short frame was discarded
//
//   Behaviour:
//     - A sample at index i lands in lane bitrev3(i) of the write bank.
//     - The 8th sample marks the bank full and moves writing to the other
//       bank; s_last on that sample carries no extra meaning.
//     - s_last before the 8th sample throws the partial frame away.
//     - s_ready and m_valid come straight from flags, so neither has a
//       combinational path from s_valid or m_ready.
//   Only N = 8 is supported; the lane index and bit reversal are 3 bits.
// ---------------------------------------------------------------------------
module fft_input_buffer
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int N      = fft_pkg::N
) (
    input  logic                clk,
    input  logic                rst_n,
    fft_input_buffer_if.slave   bus,
    output logic                frame_err
);

    ctrl_t q;
    ctrl_t d;

    logic                s_ready;
    logic                m_valid;
    logic                accept;
    logic                xfer;
    logic                last_idx;
    idx_t                wr_lane;
    logic [N*DATA_W-1:0] bank_rdata [2];

    // Handshake state is purely registered.
    assign s_ready  = ~q.full[q.wr_bank];
    assign m_valid  = q.full[q.rd_bank];

    assign accept   = bus.s_valid & s_ready;
    assign xfer     = m_valid & bus.m_ready;
    assign last_idx = (q.wr_idx == idx_t'(N - 1));
    assign wr_lane  = bitrev3(q.wr_idx);

    // Next-state logic. A completing write and a frame transfer can happen
    // in the same cycle; they always touch different banks, because a write
    // needs its bank empty and a transfer needs its bank full, so applying
    // both updates in sequence is safe.
    always_comb begin
        // NOTE: start from the current state so every field has a value on
        // every path; otherwise synthesis would infer latches here.
        d           = q;
        d.frame_err = 1'b0;

        if (xfer) begin
            d.full[q.rd_bank] = 1'b0;
            d.rd_bank         = ~q.rd_bank;
        end

        if (accept) begin
            if (last_idx) begin
                d.full[q.wr_bank] = 1'b1;
                d.wr_bank         = ~q.wr_bank;
                d.wr_idx          = '0;
            end else if (bus.s_last) begin
                // Short frame: rewind; lanes already written get overwritten
                // by the next frame, so they need no clean-up.
                d.wr_idx    = '0;
                d.frame_err = 1'b1;
            end else begin
                d.wr_idx = q.wr_idx + idx_t'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its input from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_buf_bank #(
            .DATA_W (DATA_W),
            .N      (N)
        ) u_bank (
            .clk   (clk),
            .we    (accept && (q.wr_bank == 1'(b))),
            .lane  (wr_lane),
            .wdata (bus.s_data),
            .rdata (bank_rdata[b])
        );
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = bank_rdata[q.rd_bank];
    assign frame_err   = q.frame_err;

endmodule

// File: tb/tb_fft_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_fft_input_buffer
//   Self-checking bench for fft_input_buffer. A frame-level reference model
//   (queue of completed frames plus the samples of the frame in progress)
//   predicts s_ready, m_valid, m_data and frame_err for every cycle.
// ---------------------------------------------------------------------------
module tb_fft_input_buffer;
    import fft_pkg::*;

    logic clk;
    logic rst_n;
    logic frame_err;

    fft_input_buffer_if #(.DATA_W(DATA_W), .N(N)) bus ();

    fft_input_buffer #(
        .DATA_W (DATA_W),
        .N      (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [N*DATA_W-1:0] pend [$];   // completed frames, oldest first
    logic [DATA_W-1:0]   cur  [N];   // samples of the frame being collected
    int                  cnt;        // samples collected so far
    bit                  err_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Position of sample k after bit reversal, by plain arithmetic.
    function automatic int rev3(input int k);
        return (k % 2) * 4 + ((k / 2) % 2) * 2 + (k / 4);
    endfunction

    function automatic logic [N*DATA_W-1:0] build_frame();
        logic [N*DATA_W-1:0] f;
        for (int lane = 0; lane < N; lane++) begin
            f[lane*DATA_W +: DATA_W] = cur[rev3(lane)];
        end
        return f;
    endfunction

    // One clock cycle: check outputs at the falling edge, drive new inputs,
    // then advance the model across the rising edge.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] dat, input bit last, input bit mr);
        bit acc;
        bit xf;
        bit err_next;
        @(negedge clk);
        check("s_ready", 64'(bus.s_ready), 64'(pend.size() < 2));
        check("m_valid", 64'(bus.m_valid), 64'(pend.size() > 0));
        if (pend.size() > 0) begin
            check("m_data", 64'(bus.m_data), 64'(pend[0]));
        end
        check("frame_err", 64'(frame_err), 64'(err_exp));
        bus.s_valid = v;
        bus.s_data  = dat;
        bus.s_last  = last;
        bus.m_ready = mr;
        @(posedge clk);
        acc      = v && (pend.size() < 2);
        xf       = mr && (pend.size() > 0);
        err_next = 1'b0;
        if (xf) begin
            void'(pend.pop_front());
        end
        if (acc) begin
            cur[cnt] = dat;
            if (cnt == N - 1) begin
                pend.push_back(build_frame());
                cnt = 0;
            end else if (last) begin
                cnt      = 0;
                err_next = 1'b1;
            end else begin
                cnt++;
            end
        end
        err_exp = err_next;
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, '0, 1'b0, mr);
        end
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        pend.delete();
        cnt         = 0;
        err_exp     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        cnt         = 0;
        err_exp     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Samples 0..7, sink ready: frame one cycle after the 8th sample.
        for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b1);
        #1;
        check("req031_m_valid", 64'(bus.m_valid), 64'd1);
        check("req031_lanes", 64'(bus.m_data), 64'h0703050106020400);
        idle(2, 1'b1);

        // 24 samples back-to-back, sink always ready.
        for (int i = 0; i < 24; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b1);
        idle(3, 1'b1);

        // Sink stalled: two frames fill both banks, 17th sample waits.
        for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(i + 100), 1'b0, 1'b0);
        cycle(1'b1, DATA_W'(116), 1'b0, 1'b0);
        cycle(1'b1, DATA_W'(116), 1'b0, 1'b0);
        cycle(1'b1, DATA_W'(116), 1'b0, 1'b1);
        cycle(1'b1, DATA_W'(116), 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) cycle(1'b1, DATA_W'(i + 116), 1'b0, 1'b0);
        idle(4, 1'b1);

        // Short frame of three samples, then a good frame.
        cycle(1'b1, DATA_W'(9), 1'b0, 1'b1);
        cycle(1'b1, DATA_W'(9), 1'b0, 1'b1);
        cycle(1'b1, DATA_W'(9), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b1);
        idle(3, 1'b1);

        // Reset with one full frame pending and a partial of five samples.
        for (int i = 0; i < 13; i++) cycle(1'b1, DATA_W'(i + 50), 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'(i + 200), 1'b0, 1'b1);
        idle(3, 1'b1);

        // Random traffic: bursty valid, occasional s_last, random back-pressure.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) != 0, DATA_W'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
        end
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
